// File: rtl/dmem_wait_if.sv
// Request/acknowledge bus between the core's data port and dmem_wait.
// master: requester side (core); slave: memory side.
interface dmem_wait_if #(
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              req;
  logic              we;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [BE_W-1:0]   be;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata, be,
    input  ack, rdata, err, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ack, rdata, err, busy
  );
endinterface

// File: rtl/dmem_wait.sv
// Data memory with req/ack handshake, programmable wait states, byte-lane
// write enables and misaligned/out-of-range error reporting.
// Optional macro DMEM_WAIT_FAST_READ_EN: reads bypass the wait states and
// acknowledge one cycle after acceptance; writes still honour LATENCY.
module dmem_wait #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 6,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  dmem_wait_if.slave  bus
);
  localparam int         BE_W  = DATA_W / 8;
  localparam int         DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              armed_q;
  logic              accept, enter_resp;

  logic [DATA_W-1:0] mem [DEPTH];

  // Accepted request, held for the duration of the access
  logic              we_p0;
  logic [ADDR_W-1:0] idx_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [BE_W-1:0]   be_p0;
  logic              err_p0;

  // Response registers
  logic [DATA_W-1:0] rdata_p1;
  logic              err_p1;

  // Request as seen at the edge entering RESP (live bus when that edge is
  // also the acceptance edge, latched copy otherwise)
  logic              cur_we, cur_err;
  logic [ADDR_W-1:0] cur_idx;
  logic [DATA_W-1:0] cur_wdata;
  logic [BE_W-1:0]   cur_be;

  function automatic logic decode_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
  endfunction

  // Next-state, wait counter and transfer strobes
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req && armed_q) begin
          accept = 1'b1;
          cnt_d  = LAT;
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
`ifdef DMEM_WAIT_FAST_READ_EN
          if (!bus.we) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
`endif
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Select live or latched request fields
  always_comb begin
    cur_we    = we_p0;
    cur_err   = err_p0;
    cur_idx   = idx_p0;
    cur_wdata = wdata_p0;
    cur_be    = be_p0;
    if (state_q == IDLE) begin
      cur_we    = bus.we;
      cur_err   = decode_err(bus.addr);
      cur_idx   = bus.addr[ADDR_W+1:2];
      cur_wdata = bus.wdata;
      cur_be    = bus.be;
    end
  end

  // Control state and response registers; armed_q holds off acceptance for
  // one edge after reset release so no access can start while reset is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      armed_q  <= 1'b0;
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= 1'b1;
      if (enter_resp) begin
        err_p1 <= cur_err;
        if (cur_err)
          rdata_p1 <= '0;
        else if (!cur_we)
          rdata_p1 <= mem[cur_idx];
      end
    end
  end

  // Latch the request fields at acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= bus.we;
      idx_p0   <= bus.addr[ADDR_W+1:2];
      wdata_p0 <= bus.wdata;
      be_p0    <= bus.be;
      err_p0   <= decode_err(bus.addr);
    end
  end

  // Byte-lane masked write, committed on the edge that raises ack
  always_ff @(posedge clk) begin
    if (enter_resp && cur_we && !cur_err) begin
      for (int b = 0; b < BE_W; b++) begin
        if (cur_be[b])
          mem[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
      end
    end
  end

  assign bus.ack   = (state_q == RESP);
  assign bus.busy  = (state_q != IDLE);
  assign bus.rdata = rdata_p1;
  assign bus.err   = err_p1;
endmodule

// File: tb/tb_dmem_wait.sv
// Self-checking bench for dmem_wait: vector table of accesses with a
// scoreboard of expected responses, plus reset and mid-access reset cases.
module tb_dmem_wait;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset_n;

  dmem_wait_if #(.DATA_W(32)) bus ();

  dmem_wait #(.DATA_W(32), .ADDR_W(6), .LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    bit          exp_err;
    bit          chk_rd;
    string       nm;
  } vec_t;

  typedef struct {
    int          lat;
    logic [31:0] rdata;
    bit          err;
    bit          chk_rd;
    string       nm;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[18];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, req);
    end
  endtask

  function automatic int exp_lat(input bit w);
`ifdef DMEM_WAIT_FAST_READ_EN
    return w ? LAT + 1 : 1;
`else
    return LAT + 1;
`endif
  endfunction

  // Called at a negedge; returns at the negedge after the access has ended.
  task automatic do_access(input vec_t v);
    exp_t e;
    int   n;
    int   nbusy;
    bit   got;
    e.lat    = exp_lat(v.we);
    e.rdata  = v.exp_rdata;
    e.err    = v.exp_err;
    e.chk_rd = v.chk_rd;
    e.nm     = v.nm;
    sb.push_back(e);
    bus.req   = 1'b1;
    bus.we    = v.we;
    bus.addr  = v.addr;
    bus.wdata = v.wdata;
    bus.be    = v.be;
    n = 0; nbusy = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.busy) nbusy++;
      if (bus.ack) begin
        exp_t x;
        got = 1'b1;
        x = sb.pop_front();
        chk({x.nm, "_lat"}, n, x.lat);
        chk({x.nm, "_err"}, 32'(bus.err), 32'(x.err));
        if (x.chk_rd) chk({x.nm, "_rdata"}, bus.rdata, x.rdata);
        chk({x.nm, "_busy"}, nbusy, x.lat);
        bus.req = 1'b0;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: no ack after %0d cycles, want %0d", v.nm, n, e.lat);
      void'(sb.pop_front());
      bus.req = 1'b0;
    end
    @(negedge clk);
    chk({v.nm, "_idle"}, {30'd0, bus.ack, bus.busy}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{0, 32'h0,        32'h0,        4'hF, 32'h0,        0, 0, "rd0_first"};
    vecs[1]  = '{1, 32'h0,        32'h01020304, 4'hF, 32'h0,        0, 0, "wr0"};
    vecs[2]  = '{0, 32'h0,        32'h0,        4'hF, 32'h01020304, 0, 1, "rd0"};
    vecs[3]  = '{1, 32'h10,       32'hDEADBEEF, 4'hF, 32'h01020304, 0, 1, "wr10_hold"};
    vecs[4]  = '{0, 32'h10,       32'h0,        4'hF, 32'hDEADBEEF, 0, 1, "rd10"};
    vecs[5]  = '{1, 32'h8,        32'h11223344, 4'hF, 32'hDEADBEEF, 0, 1, "wr8_pre"};
    vecs[6]  = '{1, 32'h8,        32'hAABBCCDD, 4'h5, 32'h0,        0, 0, "wr8_lanes"};
    vecs[7]  = '{0, 32'h8,        32'h0,        4'hF, 32'h11BB33DD, 0, 1, "rd8_lanes"};
    vecs[8]  = '{0, 32'h6,        32'h0,        4'hF, 32'h0,        1, 1, "rd_misal"};
    vecs[9]  = '{1, 32'h100,      32'hFFFFFFFF, 4'hF, 32'h0,        1, 0, "wr_oor"};
    vecs[10] = '{0, 32'h0,        32'h0,        4'hF, 32'h01020304, 0, 1, "rd0_after_oor"};
    vecs[11] = '{1, 32'h8,        32'h55555555, 4'h0, 32'h0,        0, 0, "wr8_be0"};
    vecs[12] = '{0, 32'h8,        32'h0,        4'hF, 32'h11BB33DD, 0, 1, "rd8_be0"};
    vecs[13] = '{1, 32'hFC,       32'hCAFEF00D, 4'hF, 32'h0,        0, 0, "wr_top"};
    vecs[14] = '{0, 32'hFC,       32'h0,        4'hF, 32'hCAFEF00D, 0, 1, "rd_top"};
    vecs[15] = '{0, 32'h80000000, 32'h0,        4'hF, 32'h0,        1, 1, "rd_oor_hi"};
    vecs[16] = '{1, 32'h3,        32'h12345678, 4'hF, 32'h0,        1, 0, "wr_misal"};
    vecs[17] = '{1, 32'h4,        32'h0,        4'hF, 32'h0,        0, 0, "wr4_zero"};

    // Reset held with a pending request
    reset_n   = 1'b0;
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 32'h0;
    bus.wdata = 32'hFFFFFFFF;
    bus.be    = 4'hF;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    bus.req = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 18; i++) do_access(vecs[i]);

    // Reset during WAIT abandons the write
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 32'h4;
    bus.wdata = 32'hFFFFFFFF;
    bus.be    = 4'hF;
    @(negedge clk);
    chk("midop_busy", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    bus.req = 1'b0;
    #1;
    chk("midop_rst_busy", 32'(bus.busy), 32'd0);
    begin
      bit seen_ack;
      seen_ack = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (bus.ack) seen_ack = 1'b1;
      end
      chk("midop_no_ack", 32'(seen_ack), 32'd0);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    begin
      vec_t v;
      v = '{0, 32'h4, 32'h0, 4'hF, 32'h0, 0, 1, "rd4_after_rst"};
      do_access(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
